// File: rtl/pwm_gen_pkg.sv
// Shared constants for the PWM generator.
package pwm_gen_pkg;

    // Default width of duty, period and the frame counter.
    localparam int unsigned PWM_WIDTH_DEFAULT = 8;

endpackage : pwm_gen_pkg

// File: rtl/pwm_gen_counter.sv
// Frame counter for the PWM generator: counts 0..period_sh_i-1 and wraps.
// term_c flags the last clock of a frame and is used to reload the shadows.
module pwm_gen_counter
    import pwm_gen_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] period_sh_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             term_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Periods of 0 or 1 pin the counter at 0 and end a frame every clock.
    always_comb begin
        term_c = 1'b0;
        cnt_d  = cnt_q;
        term_c = (period_sh_i <= WIDTH'(1)) ||
                 (cnt_q == WIDTH'(period_sh_i - WIDTH'(1)));
        cnt_d  = term_c ? '0 : WIDTH'(cnt_q + WIDTH'(1));
    end

    // Counter register; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : pwm_gen_counter

// File: rtl/pwm_gen.sv
// Fixed-frequency PWM generator. duty/period are shadowed and only taken
// at the frame boundary so every frame is glitch-free; pwm is registered.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] period,
    output logic             pwm
);

    logic [WIDTH-1:0] cnt;
    logic             term_c;

    logic [WIDTH-1:0] duty_sh_q;
    logic [WIDTH-1:0] duty_sh_d;
    logic [WIDTH-1:0] period_sh_q;
    logic [WIDTH-1:0] period_sh_d;
    logic             pwm_q;
    logic             pwm_d;

    // Wrapping frame counter with end-of-frame detect.
    pwm_gen_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .period_sh_i (period_sh_q),
        .cnt_o       (cnt),
        .term_c      (term_c)
    );

    // Shadow reload at frame end; compare uses the current frame's duty.
    always_comb begin
        duty_sh_d   = duty_sh_q;
        period_sh_d = period_sh_q;
        pwm_d       = 1'b0;
        if (term_c) begin
            duty_sh_d   = duty;
            period_sh_d = period;
        end
        pwm_d = (cnt < duty_sh_q);
    end

    // Shadow and output registers; reset clears everything, so inputs are
    // first sampled on the clock after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh_q   <= '0;
            period_sh_q <= '0;
            pwm_q       <= 1'b0;
        end else begin
            duty_sh_q   <= duty_sh_d;
            period_sh_q <= period_sh_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// Directed, table-driven bench for pwm_gen.
module tb_pwm_gen;

    logic       clk;
    logic       rst;
    logic [7:0] duty;
    logic [7:0] period;
    logic       pwm;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] duty;
        logic [7:0] period;
        int         frames;
        int         exp_high;
        int         exp_len;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    pwm_gen #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .duty   (duty),
        .period (period),
        .pwm    (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int exp);
        checks++;
        if (int'(dut.cnt) != exp) begin
            failures++;
            $display("FAIL %s: cnt got %0d required %0d", name, int'(dut.cnt), exp);
        end
    endtask

    // Advance at negedges until cnt equals target, bounded.
    task automatic wait_cnt(input int target, input int id);
        int n;
        n = 0;
        while (int'(dut.cnt) != target && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (int'(dut.cnt) != target) begin
            checks++;
            failures++;
            $display("FAIL wait_cnt id=%0d: cnt got %0d required %0d (timeout)",
                     id, int'(dut.cnt), target);
        end
    endtask

    // Skip the frame in progress and stop at the negedge where the next frame's cnt==0.
    task automatic wait_frame_start(input int id);
        @(negedge clk);
        wait_cnt(0, id);
    endtask

    // Called at a negedge with cnt==0; checks one whole frame of pwm and cnt.
    // Optionally changes duty at clock change_at within the frame.
    task automatic check_frame(input int id, input int exp_high, input int exp_len,
                               input int change_at, input logic [7:0] new_duty);
        int   bad;
        int   first_i;
        int   exp_cnt;
        int   got_cnt;
        int   want_cnt;
        logic got_pwm;
        logic want_pwm;
        bad = 0; first_i = -1; got_cnt = 0; want_cnt = 0; got_pwm = 1'b0; want_pwm = 1'b0;
        for (int i = 0; i < exp_len; i++) begin
            if (i == change_at) duty = new_duty;
            @(negedge clk);
            exp_cnt = (i == exp_len - 1) ? 0 : i + 1;
            if (pwm !== (i < exp_high) || int'(dut.cnt) != exp_cnt) begin
                if (bad == 0) begin
                    first_i  = i;
                    got_pwm  = pwm;
                    got_cnt  = int'(dut.cnt);
                    want_pwm = (i < exp_high);
                    want_cnt = exp_cnt;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL frame id=%0d: %0d bad clocks, first at clock %0d got pwm=%b cnt=%0d required pwm=%b cnt=%0d",
                     id, bad, first_i, got_pwm, got_cnt, want_pwm, want_cnt);
        end
    endtask

    initial begin
        // duty, period, frames, expected high clocks, expected frame length
        vecs[0] = '{8'd64,  8'd220, 10, 64,  220};
        vecs[1] = '{8'd0,   8'd220, 2,  0,   220};
        vecs[2] = '{8'd220, 8'd220, 2,  220, 220};
        vecs[3] = '{8'd255, 8'd220, 2,  220, 220};
        vecs[4] = '{8'd5,   8'd1,   4,  1,   1};
        vecs[5] = '{8'd5,   8'd0,   4,  1,   1};
        vecs[6] = '{8'd2,   8'd4,   4,  2,   4};
        vecs[7] = '{8'd0,   8'd1,   3,  0,   1};
        vecs[8] = '{8'd3,   8'd10,  3,  3,   10};
        vecs[9] = '{8'd9,   8'd7,   2,  7,   7};

        // Reset with unknown inputs.
        rst    = 1'b1;
        duty   = 'x;
        period = 'x;
        repeat (2) @(negedge clk);
        check_bit("reset_pwm", pwm, 1'b0);
        check_cnt("reset_cnt", 0);

        rst    = 1'b0;
        duty   = 8'd64;
        period = 8'd220;
        @(negedge clk);
        check_bit("post_reset_pwm_known", $isunknown(pwm), 1'b0);
        check_bit("post_reset_pwm", pwm, 1'b0);
        check_cnt("post_reset_cnt", 0);

        // Table of steady settings.
        for (int v = 0; v < NVEC; v++) begin
            duty   = vecs[v].duty;
            period = vecs[v].period;
            wait_frame_start(v);
            for (int f = 0; f < vecs[v].frames; f++) begin
                check_frame(v * 100 + f, vecs[v].exp_high, vecs[v].exp_len, -1, 8'd0);
            end
        end

        // Duty change mid-frame takes effect only at the next frame.
        duty   = 8'd64;
        period = 8'd220;
        wait_frame_start(1000);
        check_frame(1001, 64, 220, 50, 8'd110);
        check_frame(1002, 110, 220, -1, 8'd0);

        // Reset mid-frame at cnt==100 while pwm is high.
        duty   = 8'd150;
        period = 8'd220;
        wait_frame_start(2000);
        wait_cnt(100, 2001);
        check_bit("mid_frame_pwm_high", pwm, 1'b1);
        rst    = 1'b1;
        duty   = 8'd30;
        period = 8'd50;
        @(negedge clk);
        check_bit("mid_reset_pwm", pwm, 1'b0);
        check_cnt("mid_reset_cnt", 0);
        rst = 1'b0;
        @(negedge clk);
        check_cnt("after_release_cnt", 0);
        check_bit("after_release_pwm", pwm, 1'b0);
        check_frame(2002, 30, 50, -1, 8'd0);
        check_frame(2003, 30, 50, -1, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pwm_gen
